// File: rtl/mem_access.sv
// mem_access -- MEM pipeline stage with an external asynchronous SRAM port.
//
// A non-RAM instruction passes straight through to the MEM/WB registers with
// one cycle of latency. A RAM instruction is latched on the request cycle.
// The stage then runs a short strobe sequence on the SRAM pins and stalls
// the front of the pipeline while it does so:
//   read : IDLE(req) -> SETUP -> STROBE -> IDLE   (stall for 2 cycles)
//   write: IDLE(req) -> SETUP -> STROBE -> HOLD -> IDLE   (stall for 3 cycles)
//
// Ports
//   clk_50MHz, rst          system clock, asynchronous active-high reset
//   n_em_*                  EXE/MEM inputs (RAM enable/op, ALU result = address,
//                           store data, write-back enable and register address)
//   mem_PAUSE               combinational stall for IF/ID/EXE
//   mw_REG_op/WB_ADDR/WB_DATA  registered MEM/WB outputs
//   ram_addr, ram_wdata, ram_rdata  SRAM address and data
//   ram_data_oe             enable for the SRAM data-bus driver
//   ram_ce_n/oe_n/we_n      active-low SRAM strobes
module mem_access #(
   parameter int DATA_W    = 16,
   parameter int WB_ADDR_W = 4
) (
   input  logic                 clk_50MHz,
   input  logic                 rst,
   input  logic                 n_em_RAM_en,
   input  logic                 n_em_RAM_op,
   input  logic [DATA_W-1:0]    n_em_ALU_RES,
   input  logic [DATA_W-1:0]    n_em_WDATA,
   input  logic                 n_em_REG_op,
   input  logic [WB_ADDR_W-1:0] n_em_WB_ADDR,
   output logic                 mem_PAUSE,
   output logic                 mw_REG_op,
   output logic [WB_ADDR_W-1:0] mw_WB_ADDR,
   output logic [DATA_W-1:0]    mw_WB_DATA,
   output logic [DATA_W-1:0]    ram_addr,
   output logic [DATA_W-1:0]    ram_wdata,
   input  logic [DATA_W-1:0]    ram_rdata,
   output logic                 ram_data_oe,
   output logic                 ram_ce_n,
   output logic                 ram_oe_n,
   output logic                 ram_we_n
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      STROBE = 2'd2,
      HOLD   = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_next;

   // Copies of the request, taken in IDLE and used for the whole access so
   // that the upstream stages may change their outputs freely meanwhile.
   logic [DATA_W-1:0]     r_addr;
   logic [DATA_W-1:0]     r_wdata;
   logic                  r_op;
   logic                  r_reg_op;
   logic [WB_ADDR_W-1:0]  r_wb_addr;

   logic                  r_mw_reg_op;
   logic [WB_ADDR_W-1:0]  r_mw_wb_addr;
   logic [DATA_W-1:0]     r_mw_wb_data;

   logic                  w_pause;
   logic                  w_data_oe;
   logic                  w_ce_n;
   logic                  w_oe_n;
   logic                  w_we_n;

   // Next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (n_em_RAM_en) w_next = SETUP;
         SETUP:   w_next = STROBE;
         STROBE:  w_next = r_op ? HOLD : IDLE;
         HOLD:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Strobes decode from the state register alone, so an asynchronous reset
   // (which forces IDLE) releases every strobe at once.
   always_comb begin
      w_pause   = 1'b0;
      w_data_oe = 1'b0;
      w_ce_n    = 1'b1;
      w_oe_n    = 1'b1;
      w_we_n    = 1'b1;
      case (r_state)
         IDLE: begin
            // Stall in the request cycle itself; masked during reset.
            w_pause = n_em_RAM_en & ~rst;
         end
         SETUP: begin
            w_pause = 1'b1;
            w_ce_n  = 1'b0;
            if (r_op) w_data_oe = 1'b1;
            else      w_oe_n    = 1'b0;
         end
         STROBE: begin
            w_ce_n = 1'b0;
            if (r_op) begin
               w_we_n    = 1'b0;
               w_data_oe = 1'b1;
               w_pause   = 1'b1;
            end else begin
               // Read data is captured at the edge that leaves this state,
               // so upstream may already advance here.
               w_oe_n = 1'b0;
            end
         end
         HOLD: begin
            // The write-enable rises while address and data stay driven,
            // which gives the SRAM its data hold time.
            w_ce_n    = 1'b0;
            w_data_oe = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_50MHz or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_op         <= 1'b0;
         r_reg_op     <= 1'b0;
         r_wb_addr    <= '0;
         r_mw_reg_op  <= 1'b0;
         r_mw_wb_addr <= '0;
         r_mw_wb_data <= '0;
      end else begin
         r_state     <= w_next;
         // Default is a bubble: nothing writes back unless an instruction
         // completes at this edge. The write-back address and data hold.
         r_mw_reg_op <= 1'b0;
         case (r_state)
            IDLE: begin
               if (n_em_RAM_en) begin
                  r_addr    <= n_em_ALU_RES;
                  r_wdata   <= n_em_WDATA;
                  r_op      <= n_em_RAM_op;
                  r_reg_op  <= n_em_REG_op;
                  r_wb_addr <= n_em_WB_ADDR;
               end else begin
                  r_mw_reg_op  <= n_em_REG_op;
                  r_mw_wb_addr <= n_em_WB_ADDR;
                  r_mw_wb_data <= n_em_ALU_RES;
               end
            end
            STROBE: begin
               if (!r_op) begin
                  r_mw_reg_op  <= r_reg_op;
                  r_mw_wb_addr <= r_wb_addr;
                  r_mw_wb_data <= ram_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_PAUSE   = w_pause;
   assign mw_REG_op   = r_mw_reg_op;
   assign mw_WB_ADDR  = r_mw_wb_addr;
   assign mw_WB_DATA  = r_mw_wb_data;
   assign ram_addr    = r_addr;
   assign ram_wdata   = r_wdata;
   assign ram_data_oe = w_data_oe;
   assign ram_ce_n    = w_ce_n;
   assign ram_oe_n    = w_oe_n;
   assign ram_we_n    = w_we_n;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: ALU pass-through, load, store, load followed
// by store, reset during a write strobe, and inputs changing during an access.
module tb_mem_access;

   localparam int DATA_W    = 16;
   localparam int WB_ADDR_W = 4;

   logic                 clk_50MHz = 1'b0;
   logic                 rst;
   logic                 n_em_RAM_en;
   logic                 n_em_RAM_op;
   logic [DATA_W-1:0]    n_em_ALU_RES;
   logic [DATA_W-1:0]    n_em_WDATA;
   logic                 n_em_REG_op;
   logic [WB_ADDR_W-1:0] n_em_WB_ADDR;
   logic                 mem_PAUSE;
   logic                 mw_REG_op;
   logic [WB_ADDR_W-1:0] mw_WB_ADDR;
   logic [DATA_W-1:0]    mw_WB_DATA;
   logic [DATA_W-1:0]    ram_addr;
   logic [DATA_W-1:0]    ram_wdata;
   logic [DATA_W-1:0]    ram_rdata;
   logic                 ram_data_oe;
   logic                 ram_ce_n;
   logic                 ram_oe_n;
   logic                 ram_we_n;

   int n_tot = 0;
   int n_bad = 0;

   always #10 clk_50MHz = ~clk_50MHz;

   mem_access #(.DATA_W(DATA_W), .WB_ADDR_W(WB_ADDR_W)) dut (
      .clk_50MHz   (clk_50MHz),
      .rst         (rst),
      .n_em_RAM_en (n_em_RAM_en),
      .n_em_RAM_op (n_em_RAM_op),
      .n_em_ALU_RES(n_em_ALU_RES),
      .n_em_WDATA  (n_em_WDATA),
      .n_em_REG_op (n_em_REG_op),
      .n_em_WB_ADDR(n_em_WB_ADDR),
      .mem_PAUSE   (mem_PAUSE),
      .mw_REG_op   (mw_REG_op),
      .mw_WB_ADDR  (mw_WB_ADDR),
      .mw_WB_DATA  (mw_WB_DATA),
      .ram_addr    (ram_addr),
      .ram_wdata   (ram_wdata),
      .ram_rdata   (ram_rdata),
      .ram_data_oe (ram_data_oe),
      .ram_ce_n    (ram_ce_n),
      .ram_oe_n    (ram_oe_n),
      .ram_we_n    (ram_we_n)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tot++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are then driven 2ns after the edge and
   // outputs are checked mid-cycle, well away from either edge.
   task automatic cyc();
      @(posedge clk_50MHz);
      #2;
   endtask

   task automatic drive(input logic en, input logic op, input logic [15:0] alu,
                        input logic [15:0] wd, input logic rop, input logic [3:0] wa);
      n_em_RAM_en  = en;
      n_em_RAM_op  = op;
      n_em_ALU_RES = alu;
      n_em_WDATA   = wd;
      n_em_REG_op  = rop;
      n_em_WB_ADDR = wa;
      #5;
   endtask

   task automatic nop();
      drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4'h0);
   endtask

   initial begin
      rst       = 1'b1;
      ram_rdata = 16'h0000;
      // RAM_en high during reset must not raise the stall.
      drive(1'b1, 1'b1, 16'h1111, 16'h2222, 1'b1, 4'hF);
      cyc();
      #5;
      chk("rst_pause",   mem_PAUSE,   0);
      chk("rst_regop",   mw_REG_op,   0);
      chk("rst_wbaddr",  mw_WB_ADDR,  0);
      chk("rst_wbdata",  mw_WB_DATA,  0);
      chk("rst_ce",      ram_ce_n,    1);
      chk("rst_oe",      ram_oe_n,    1);
      chk("rst_we",      ram_we_n,    1);
      chk("rst_doe",     ram_data_oe, 0);
      chk("rst_addr",    ram_addr,    0);
      chk("rst_wdata",   ram_wdata,   0);
      rst = 1'b0;
      nop();

      // ALU pass-through
      cyc();
      drive(1'b0, 1'b0, 16'h1234, 16'h0000, 1'b1, 4'd3);
      chk("alu_pause0", mem_PAUSE, 0);
      cyc();
      nop();
      chk("alu_data",   mw_WB_DATA, 16'h1234);
      chk("alu_waddr",  mw_WB_ADDR, 3);
      chk("alu_regop",  mw_REG_op,  1);
      chk("alu_pause1", mem_PAUSE,  0);

      // Load from 0x00A0, address input changes during SETUP
      cyc();
      ram_rdata = 16'hBEEF;
      drive(1'b1, 1'b0, 16'h00A0, 16'h0000, 1'b1, 4'd5);
      chk("ld_req_pause", mem_PAUSE, 1);
      cyc();                                   // SETUP
      drive(1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 4'd9);
      chk("ld_su_pause", mem_PAUSE,   1);
      chk("ld_su_ce",    ram_ce_n,    0);
      chk("ld_su_oe",    ram_oe_n,    0);
      chk("ld_su_we",    ram_we_n,    1);
      chk("ld_su_doe",   ram_data_oe, 0);
      chk("ld_su_addr",  ram_addr,    16'h00A0);
      chk("ld_su_regop", mw_REG_op,   0);
      cyc();                                   // STROBE
      chk("ld_st_pause", mem_PAUSE, 0);
      chk("ld_st_oe",    ram_oe_n,  0);
      chk("ld_st_ce",    ram_ce_n,  0);
      chk("ld_st_addr",  ram_addr,  16'h00A0);
      nop();
      cyc();                                   // IDLE
      chk("ld_data",  mw_WB_DATA, 16'hBEEF);
      chk("ld_regop", mw_REG_op,  1);
      chk("ld_waddr", mw_WB_ADDR, 5);
      chk("ld_id_oe", ram_oe_n,   1);
      chk("ld_id_ce", ram_ce_n,   1);
      chk("ld_hold_addr", ram_addr, 16'h00A0);
      chk("ld_id_pause", mem_PAUSE, 0);

      // Store 0x5A5A to 0x0010
      cyc();
      drive(1'b1, 1'b1, 16'h0010, 16'h5A5A, 1'b1, 4'd7);
      chk("st_req_pause", mem_PAUSE, 1);
      chk("st_req_we",    ram_we_n,  1);
      cyc();                                   // SETUP
      chk("st_su_pause", mem_PAUSE,   1);
      chk("st_su_doe",   ram_data_oe, 1);
      chk("st_su_wdata", ram_wdata,   16'h5A5A);
      chk("st_su_we",    ram_we_n,    1);
      chk("st_su_oe",    ram_oe_n,    1);
      chk("st_su_ce",    ram_ce_n,    0);
      chk("st_su_addr",  ram_addr,    16'h0010);
      cyc();                                   // STROBE
      chk("st_st_we",    ram_we_n,    0);
      chk("st_st_pause", mem_PAUSE,   1);
      chk("st_st_doe",   ram_data_oe, 1);
      chk("st_st_ce",    ram_ce_n,    0);
      cyc();                                   // HOLD
      nop();
      chk("st_ho_we",    ram_we_n,    1);
      chk("st_ho_ce",    ram_ce_n,    0);
      chk("st_ho_doe",   ram_data_oe, 1);
      chk("st_ho_pause", mem_PAUSE,   0);
      chk("st_ho_wdata", ram_wdata,   16'h5A5A);
      chk("st_ho_addr",  ram_addr,    16'h0010);
      chk("st_ho_regop", mw_REG_op,   0);
      cyc();                                   // IDLE
      chk("st_regop",  mw_REG_op,   0);
      chk("st_id_doe", ram_data_oe, 0);
      chk("st_id_ce",  ram_ce_n,    1);

      // Load immediately followed by a store
      cyc();
      ram_rdata = 16'h1357;
      drive(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b1, 4'd2);
      chk("bb_p0", mem_PAUSE, 1);
      cyc();                                   // SETUP (load)
      chk("bb_p1", mem_PAUSE, 1);
      cyc();                                   // STROBE (load)
      chk("bb_p2", mem_PAUSE, 0);
      drive(1'b1, 1'b1, 16'h0050, 16'h2468, 1'b0, 4'd1);
      cyc();                                   // IDLE with store request
      chk("bb_p3",     mem_PAUSE,  1);
      chk("bb_ldata",  mw_WB_DATA, 16'h1357);
      chk("bb_lregop", mw_REG_op,  1);
      chk("bb_lwaddr", mw_WB_ADDR, 2);
      cyc();                                   // SETUP (store)
      chk("bb_p4",    mem_PAUSE, 1);
      chk("bb_saddr", ram_addr,  16'h0050);
      chk("bb_swd",   ram_wdata, 16'h2468);
      cyc();                                   // STROBE (store)
      chk("bb_p5",  mem_PAUSE, 1);
      chk("bb_swe", ram_we_n,  0);
      cyc();                                   // HOLD
      nop();
      chk("bb_p6", mem_PAUSE, 0);
      cyc();
      chk("bb_sregop", mw_REG_op,  0);
      chk("bb_sdata",  mw_WB_DATA, 16'h1357);

      // Reset during write STROBE
      cyc();
      drive(1'b1, 1'b1, 16'h0033, 16'hCAFE, 1'b1, 4'd6);
      cyc();                                   // SETUP
      cyc();                                   // STROBE
      chk("ra_we_pre", ram_we_n, 0);
      #1 rst = 1'b1;
      #1;
      chk("ra_we",    ram_we_n,    1);
      chk("ra_doe",   ram_data_oe, 0);
      chk("ra_ce",    ram_ce_n,    1);
      chk("ra_pause", mem_PAUSE,   0);
      chk("ra_regop", mw_REG_op,   0);
      chk("ra_addr",  ram_addr,    0);
      #2 rst = 1'b0;
      // First edge after reset is evaluated as IDLE.
      drive(1'b0, 1'b0, 16'h0777, 16'h0000, 1'b1, 4'd4);
      cyc();
      nop();
      chk("pr_data",  mw_WB_DATA, 16'h0777);
      chk("pr_regop", mw_REG_op,  1);
      chk("pr_waddr", mw_WB_ADDR, 4);
      chk("pr_we",    ram_we_n,   1);
      cyc();
      chk("pr_bubble", mw_REG_op, 0);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule
